btn_conditioner: RTL and testbench
==================================

# btn_conditioner

Push-button input conditioner that sits directly upstream of the 7-segment state-machine stage and produces its one-bit `in` control. It synchronises a raw, bouncing button, debounces it, and emits a clean level, single-cycle press/release pulses, auto-repeat pulses while held, and a sticky `pend` flag with an `ack` handshake. The flag lets the consumer, which samples on the slow divided clock, never miss a short press.

## Interface

Parameters:
- `DB_CYCLES`, 32'd250000: stable cycles required to accept a change; minimum 1.
- `REPEAT_EN`, 1'b1: enables auto-repeat pulses.
- `REPEAT_DELAY`, 32'd25000000: cycles from `press` to the first `rep`; minimum 1.
- `REPEAT_PERIOD`, 32'd6250000: cycles between subsequent `rep` pulses; minimum 1.
- `BTN_ACTIVE_LOW`, 1'b0: 1 inverts `btn` after synchronisation.

Ports (one clock; reset is asynchronous and active-low):
- `clk`, input, 1: system clock; all logic is on the rising edge.
- `reset`, input, 1: asynchronous active-low reset.
- `btn`, input, 1: raw button, asynchronous to `clk`.
- `ack`, input, 1: consumer clears `pend`.
- `level`, output, 1: debounced button state (1 = pressed).
- `press`, output, 1: one-cycle pulse on accepted press.
- `release`, output, 1: one-cycle pulse on accepted release.
- `rep`, output, 1: one-cycle auto-repeat pulse.
- `pend`, output, 1: sticky event flag.

## Operation

- Synchroniser:
  - 2-FF chain, reset to the inactive raw value.
  - `btn_s` = `sync[1]` XOR `BTN_ACTIVE_LOW`.
- Debounce counter `cnt`, 32-bit:
  - Cleared on every state change.
  - Increments while in a WAIT state with the candidate value stable.
- State machine: IDLE, PRESS_WAIT, HELD, RELEASE_WAIT. Reset state is IDLE.
- IDLE (`level`=0):
  - `btn_s`=1 → PRESS_WAIT.
- PRESS_WAIT (`level`=0):
  - `btn_s`=0 → IDLE. No pulse; this is a bounce.
  - `btn_s`=1 and `cnt`==DB_CYCLES-1 → HELD, with `level`=1 and `press`=1 registered on that edge.
  - Otherwise `cnt`+1.
- HELD (`level`=1):
  - `btn_s`=0 → RELEASE_WAIT.
  - Repeat counter `rcnt` (32-bit) is cleared on entry from PRESS_WAIT.
  - With `REPEAT_EN`=1, the first `rep` fires REPEAT_DELAY cycles after `press`; each later `rep` fires REPEAT_PERIOD cycles after the previous one.
- RELEASE_WAIT (`level`=1):
  - `btn_s`=1 → HELD. `rcnt` is frozen in RELEASE_WAIT and resumes on return, so a release bounce does not restart the repeat schedule.
  - `cnt`==DB_CYCLES-1 with `btn_s`=0 → IDLE, with `level`=0 and `release`=1 on that edge.
- `pend`:
  - Set on any cycle where `press` or `rep` is registered 1.
  - Cleared on `ack`=1 when no set event occurs in the same cycle.
  - A set and `ack` in the same cycle leaves `pend`=1; the set wins.
  - `ack` with `pend`=0 has no effect.
- Counters never wrap in practice: each is cleared at its terminal count, before 2^32.

## Timing

- Reset values: `level`, `press`, `release`, `rep`, `pend` all 0; state IDLE; `cnt`, `rcnt` and the synchroniser cleared. Reset takes effect immediately and asynchronously.
- Deassertion of `reset` mid-press always requires a full debounce: IDLE → PRESS_WAIT → HELD, even if `btn` is held continuously.
- All outputs are registered; there are no combinational paths from input to output.
- Press latency: edge 0 is the first edge that samples active `btn`.
  - `btn_s`=1 after edge 1.
  - PRESS_WAIT after edge 2.
  - `level` and `press` become 1 after edge DB_CYCLES+2.
- Release latency is symmetric: `level`=0 and `release`=1 after edge DB_CYCLES+2, counted from the first edge that samples inactive `btn`.
- `press`, `release` and `rep` are each high for exactly one cycle. `press` and `rep` never coincide.
- Example: with `press` at edge P, `rep` fires at P+REPEAT_DELAY, then P+REPEAT_DELAY+k·REPEAT_PERIOD, as long as the state stays HELD.
- No `rep` is issued in RELEASE_WAIT, and none after `release`.

## Test plan

Parameters for all scenarios: DB_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5.

1. Reset: hold `reset`=0 and toggle `btn` every cycle → all outputs stay 0. Pull `reset` low asynchronously mid-cycle → outputs drop to 0 without waiting for a clock edge.
2. Clean press: `btn`=1 from edge 0, held 8 cycles, then 0 → `level`/`press` after edge 6 with `press` high one cycle; `release` at edge 6 relative to the falling sample, with `level` back to 0.
3. Bounce: `btn` pattern 1,1,1,0,1,0 then steady 1 → no `press` during bounces; exactly one `press`, 6 edges after the start of the steady 1; no `release`.
4. Auto-repeat: hold `btn` so that `press` is at edge P → `rep` at P+10, P+15, P+20, P+25. Insert a 2-cycle low glitch in HELD → no `release`, and the repeat schedule is shifted only by the frozen cycles.
5. Handshake: after `press`, `pend`=1. Assert `ack` for one cycle → `pend`=0 next edge. Assert `ack` coincident with a `rep` → `pend` remains 1.
6. Reset mid-hold: in HELD with `btn` kept at 1, pulse `reset` low → outputs 0. After release, `level` returns to 1 only after edge DB_CYCLES+2, with a fresh `press` and `pend`.

Source files
------------

// File: rtl/btn_conditioner.sv
// Push-button conditioner: 2-FF synchroniser, debounce FSM, press/release/repeat pulses
// and a sticky pend flag with ack. `release` is a reserved word, so that output is `rel`.
module btn_conditioner #(
    parameter logic [31:0] DB_CYCLES      = 32'd250000,
    parameter logic        REPEAT_EN      = 1'b1,
    parameter logic [31:0] REPEAT_DELAY   = 32'd25000000,
    parameter logic [31:0] REPEAT_PERIOD  = 32'd6250000,
    parameter logic        BTN_ACTIVE_LOW = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    input  logic ack,
    output logic level,
    output logic press,
    output logic rel,
    output logic rep,
    output logic pend
);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } state_t;

    state_t      state, state_n;
    logic [1:0]  sync;
    logic        btn_s;
    logic [31:0] cnt, cnt_n;
    logic [31:0] rcnt, rcnt_n;
    logic [31:0] rep_last;
    logic        rep_first, rep_first_n;
    logic        level_n, press_n, rel_n, rep_n, pend_n;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync <= {2{BTN_ACTIVE_LOW}};
        end else begin
            sync <= {sync[0], btn};
        end
    end

    assign btn_s = sync[1] ^ BTN_ACTIVE_LOW;

    // First repeat waits REPEAT_DELAY, later ones REPEAT_PERIOD.
    assign rep_last = rep_first ? (REPEAT_DELAY - 32'd1) : (REPEAT_PERIOD - 32'd1);

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        rcnt_n      = rcnt;
        rep_first_n = rep_first;
        level_n     = level;
        press_n     = 1'b0;
        rel_n       = 1'b0;
        rep_n       = 1'b0;
        case (state)
            IDLE: begin
                if (btn_s) begin
                    state_n = PRESS_WAIT;
                    cnt_n   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!btn_s) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (cnt == DB_CYCLES - 32'd1) begin
                    state_n     = HELD;
                    cnt_n       = '0;
                    rcnt_n      = '0;
                    rep_first_n = 1'b1;
                    level_n     = 1'b1;
                    press_n     = 1'b1;
                end else begin
                    cnt_n = cnt + 32'd1;
                end
            end
            HELD: begin
                if (!btn_s) begin
                    state_n = RELEASE_WAIT;
                    cnt_n   = '0;
                end else if (REPEAT_EN) begin
                    if (rcnt == rep_last) begin
                        rep_n       = 1'b1;
                        rcnt_n      = '0;
                        rep_first_n = 1'b0;
                    end else begin
                        rcnt_n = rcnt + 32'd1;
                    end
                end
            end
            RELEASE_WAIT: begin
                // rcnt is left untouched here so a release bounce keeps the repeat schedule.
                if (btn_s) begin
                    state_n = HELD;
                    cnt_n   = '0;
                end else if (cnt == DB_CYCLES - 32'd1) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    level_n = 1'b0;
                    rel_n   = 1'b1;
                end else begin
                    cnt_n = cnt + 32'd1;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
                level_n = 1'b0;
            end
        endcase
        pend_n = (press_n || rep_n) ? 1'b1 : (ack ? 1'b0 : pend);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            rcnt      <= '0;
            rep_first <= 1'b1;
            level     <= 1'b0;
            press     <= 1'b0;
            rel       <= 1'b0;
            rep       <= 1'b0;
            pend      <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            rcnt      <= rcnt_n;
            rep_first <= rep_first_n;
            level     <= level_n;
            press     <= press_n;
            rel       <= rel_n;
            rep       <= rep_n;
            pend      <= pend_n;
        end
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: run-length debounce model compared every cycle,
// plus directed press / bounce / repeat / handshake / reset scenarios.
module tb_btn_conditioner;

    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RP = 5;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic btn   = 1'b0;
    logic ack   = 1'b0;
    logic level, press, rel, rep, pend;

    int n_pass  = 0;
    int n_total = 0;
    int edge_n  = 0;
    int pq[$];
    int rq[$];
    int lq[$];

    btn_conditioner #(
        .DB_CYCLES     (32'd4),
        .REPEAT_EN     (1'b1),
        .REPEAT_DELAY  (32'd10),
        .REPEAT_PERIOD (32'd5),
        .BTN_ACTIVE_LOW(1'b0)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .btn  (btn),
        .ack  (ack),
        .level(level),
        .press(press),
        .rel  (rel),
        .rep  (rep),
        .pend (pend)
    );

    always #5 clk = ~clk;

    // Model: level flips once btn_s has disagreed with it for DB+1 consecutive edges;
    // repeats fall on hold-tick numbers RD, RD+RP, RD+2RP, ...
    logic m_s0 = 0, m_s1 = 0, m_level = 0, m_press = 0, m_rel = 0, m_rep = 0, m_pend = 0;
    int   m_run = 0, m_ticks = 0;
    logic n_level, n_press, n_rel, n_rep, n_pend, tick;
    int   n_run, n_ticks;

    always_comb begin
        n_run   = 0;
        n_ticks = m_ticks;
        n_level = m_level;
        n_press = 1'b0;
        n_rel   = 1'b0;
        n_rep   = 1'b0;
        tick    = m_level && (m_run == 0) && m_s1;
        if (m_s1 != m_level) begin
            n_run = m_run + 1;
            if (n_run == DB + 1) begin
                n_level = !m_level;
                n_run   = 0;
                if (n_level) begin
                    n_press = 1'b1;
                    n_ticks = 0;
                end else begin
                    n_rel = 1'b1;
                end
            end
        end
        if (tick) begin
            n_ticks = m_ticks + 1;
            if (n_ticks == RD || (n_ticks > RD && (n_ticks - RD) % RP == 0)) n_rep = 1'b1;
        end
        n_pend = (n_press || n_rep) ? 1'b1 : (ack ? 1'b0 : m_pend);
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_s0 <= 0; m_s1 <= 0; m_run <= 0; m_ticks <= 0; m_level <= 0;
            m_press <= 0; m_rel <= 0; m_rep <= 0; m_pend <= 0;
        end else begin
            m_s0 <= btn; m_s1 <= m_s0; m_run <= n_run; m_ticks <= n_ticks;
            m_level <= n_level; m_press <= n_press; m_rel <= n_rel;
            m_rep <= n_rep; m_pend <= n_pend;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s at edge %0d: got %0d expected %0d", name, edge_n, got, exp);
    endtask

    always @(posedge clk) begin
        edge_n <= edge_n + 1;
        #1;
        chk("level", level, m_level);
        chk("press", press, m_press);
        chk("release", rel, m_rel);
        chk("rep", rep, m_rep);
        chk("pend", pend, m_pend);
        if (reset) begin
            if (press) pq.push_back(edge_n);
            if (rep)   rq.push_back(edge_n);
            if (rel)   lq.push_back(edge_n);
        end
    end

    // Returns at the negedge just before edge x, so inputs set now are sampled at edge x.
    task automatic at(input int x);
        int guard = 0;
        while (edge_n != x - 1) begin
            @(negedge clk);
            guard++;
            if (guard > 2000) begin
                n_total++;
                $display("FAIL timeout waiting for edge %0d: now %0d", x, edge_n);
                $display("%0d/%0d checks passed", n_pass, n_total);
                $fatal(1);
            end
        end
    endtask

    function automatic int qget(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic clear_q();
        pq.delete(); rq.delete(); lq.delete();
    endtask

    logic [5:0] pat = 6'b010111;
    int e0, e1, s, p;
    int exp_r[5];

    initial begin
        // Reset held with a toggling button.
        repeat (6) begin
            @(negedge clk);
            btn = ~btn;
        end
        @(negedge clk);
        chk("rst_level", level, 0);
        chk("rst_press", press, 0);
        chk("rst_release", rel, 0);
        chk("rst_rep", rep, 0);
        chk("rst_pend", pend, 0);
        btn = 0;
        reset = 1;
        repeat (2) @(negedge clk);

        // Clean press then release.
        clear_q();
        e0 = edge_n + 1;
        btn = 1;
        at(e0 + 6);
        chk("clean_level_early", level, 0);
        at(e0 + 7);
        chk("clean_level", level, 1);
        chk("clean_press", press, 1);
        at(e0 + 8);
        btn = 0;
        e1 = e0 + 8;
        chk("clean_press_1cyc", press, 0);
        at(e1 + 7);
        chk("clean_release", rel, 1);
        chk("clean_level_low", level, 0);
        chk("clean_press_cnt", pq.size(), 1);
        chk("clean_press_edge", qget(pq, 0), e0 + 6);
        chk("clean_release_edge", qget(lq, 0), e1 + 6);
        chk("clean_rep_cnt", rq.size(), 0);
        at(e1 + 8);
        ack = 1;
        at(e1 + 9);
        ack = 0;
        chk("ack_clear_1", pend, 0);
        repeat (2) @(negedge clk);

        // Bounce then steady hold, handshake, repeats and a held glitch.
        clear_q();
        s = edge_n + 1;
        for (int i = 0; i < 6; i++) begin
            btn = pat[i];
            @(negedge clk);
        end
        btn = 1;
        p = s + 12;
        at(p);
        chk("bounce_level_early", level, 0);
        chk("bounce_pend_early", pend, 0);
        at(p + 1);
        chk("bounce_press", press, 1);
        chk("bounce_pend", pend, 1);
        chk("bounce_press_cnt", pq.size(), 1);
        chk("bounce_press_edge", qget(pq, 0), p);
        at(p + 2);
        ack = 1;
        at(p + 3);
        ack = 0;
        chk("ack_clear_2", pend, 0);
        at(p + 10);
        ack = 1;
        at(p + 11);
        ack = 0;
        chk("ack_rep_rep", rep, 1);
        chk("ack_rep_pend", pend, 1);
        at(p + 12);
        ack = 1;
        at(p + 13);
        ack = 0;
        chk("ack_clear_3", pend, 0);
        at(p + 27);
        btn = 0;
        at(p + 29);
        btn = 1;
        at(p + 36);
        exp_r = '{p + 10, p + 15, p + 20, p + 25, p + 33};
        chk("rep_cnt", rq.size(), 5);
        for (int i = 0; i < 5; i++) chk("rep_edge", qget(rq, i), exp_r[i]);
        chk("glitch_no_release", lq.size(), 0);
        chk("glitch_level", level, 1);
        chk("glitch_press_cnt", pq.size(), 1);

        // Asynchronous reset mid-hold, button kept pressed.
        #2 reset = 0;
        #1;
        chk("async_level", level, 0);
        chk("async_press", press, 0);
        chk("async_release", rel, 0);
        chk("async_rep", rep, 0);
        chk("async_pend", pend, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1;
        clear_q();
        e0 = edge_n + 1;
        at(e0 + 6);
        chk("rehold_level_early", level, 0);
        at(e0 + 7);
        chk("rehold_level", level, 1);
        chk("rehold_press", press, 1);
        chk("rehold_pend", pend, 1);
        chk("rehold_press_edge", qget(pq, 0), e0 + 6);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
